// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - select/enable scan sequencer for a 3-to-8 decoder
// Walks enabled channels in ascending order with a dwell per channel and a one-cycle blanking gap.
module decoder_scan_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [2**SEL_W-1:0]   mask,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [SEL_W-1:0]      sel,
    output logic                  en,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);
    localparam int N = 2**SEL_W;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t              state, state_n;
    logic [SEL_W-1:0]    sel_n;
    logic                en_n, busy_n, frame_done_n, err_n;
    logic                stop_pending, stop_pending_n;
    logic [DWELL_W-1:0]  cnt, cnt_n;
    logic [DWELL_W-1:0]  dwell_q, dwell_q_n;
    logic [N-1:0]        mask_q, mask_q_n;
    logic [DWELL_W-1:0]  dwell_eff;
    logic [SEL_W-1:0]    low_idx, next_idx, probe;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Descending loops so the lowest index / smallest forward offset wins.
    always_comb begin
        low_idx  = '0;
        next_idx = sel;
        probe    = sel;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) low_idx = SEL_W'(i);
        end
        for (int i = N - 1; i >= 1; i--) begin
            probe = sel + SEL_W'(i);
            if (mask_q[probe]) next_idx = probe;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= '0;
            en           <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
            stop_pending <= 1'b0;
            cnt          <= '0;
            dwell_q      <= '0;
            mask_q       <= '0;
        end else begin
            state        <= state_n;
            sel          <= sel_n;
            en           <= en_n;
            busy         <= busy_n;
            frame_done   <= frame_done_n;
            err          <= err_n;
            stop_pending <= stop_pending_n;
            cnt          <= cnt_n;
            dwell_q      <= dwell_q_n;
            mask_q       <= mask_q_n;
        end
    end

    always_comb begin
        state_n        = state;
        sel_n          = sel;
        en_n           = en;
        busy_n         = busy;
        frame_done_n   = 1'b0;
        err_n          = 1'b0;
        stop_pending_n = stop_pending;
        cnt_n          = cnt;
        dwell_q_n      = dwell_q;
        mask_q_n       = mask_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mask != '0) begin
                        state_n        = RUN;
                        mask_q_n       = mask;
                        dwell_q_n      = dwell_eff;
                        cnt_n          = dwell_eff - DWELL_W'(1);
                        sel_n          = low_idx;
                        en_n           = 1'b1;
                        busy_n         = 1'b1;
                        stop_pending_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                stop_pending_n = stop_pending | stop;
                if (cnt == '0) begin
                    state_n = GAP;
                    en_n    = 1'b0;
                end else begin
                    cnt_n = cnt - DWELL_W'(1);
                end
            end
            GAP: begin
                if (stop_pending || stop) begin
                    state_n        = IDLE;
                    busy_n         = 1'b0;
                    stop_pending_n = 1'b0;
                end else begin
                    state_n      = RUN;
                    en_n         = 1'b1;
                    sel_n        = next_idx;
                    cnt_n        = dwell_q - DWELL_W'(1);
                    frame_done_n = (next_idx <= sel);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb/tb_decoder_scan_sequencer.sv - self-checking bench for decoder_scan_sequencer
module tb_decoder_scan_sequencer;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [7:0] mask = '0, dwell = '0;
    logic [2:0] sel;
    logic       en, busy, frame_done, err;
    int         cmp = 0, mis = 0;

    decoder_scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask), .dwell(dwell),
        .sel(sel), .en(en), .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    wire [6:0] obs = {sel, en, busy, frame_done, err};

    // Scan viewed as elapsed time t since start: slot = dwell+1 cycles, channel = slot mod count.
    bit         m_busy, m_stop, m_err;
    int         t, d;
    int         chans[$];
    logic [2:0] m_hold;

    function automatic void model_reset();
        m_busy = 0; m_stop = 0; m_err = 0; t = 0; d = 1; m_hold = '0; chans.delete();
    endfunction

    function automatic void model_step(input bit s, input bit p);
        int pos;
        m_err = 0;
        if (!m_busy) begin
            if (s) begin
                if (mask == 0) m_err = 1;
                else begin
                    chans.delete();
                    for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
                    d = (dwell == 0) ? 1 : int'(dwell);
                    t = 0; m_busy = 1; m_stop = 0;
                end
            end
        end else begin
            pos = t % (d + 1);
            m_stop = m_stop | p;
            if (pos == d && m_stop) begin
                m_busy = 0;
                m_hold = 3'(chans[(t / (d + 1)) % chans.size()]);
            end else t++;
        end
    endfunction

    function automatic logic [6:0] exp_vec();
        int pos, k;
        if (!m_busy) return {m_hold, 1'b0, 1'b0, 1'b0, m_err};
        pos = t % (d + 1);
        k = (t / (d + 1)) % chans.size();
        return {3'(chans[k]), pos < d, 1'b1, (pos == 0 && t > 0 && k == 0), 1'b0};
    endfunction

    task automatic tick(input bit s, input bit p);
        start = s; stop = p;
        @(posedge clk);
        model_step(s, p);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL reset got=%h exp=%h", obs, exp_vec()); end
        rst = 1'b0;
        tick(0, 1);
        cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_full_mask();
        int fd_cnt = 0;
        mask = 8'hFF; dwell = 8'd2;
        tick(1, 0);
        for (int i = 0; i < 27; i++) begin
            cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL full_mask cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
            if (frame_done) fd_cnt++;
            tick(0, 0);
        end
        cmp++; if (fd_cnt !== 1) begin mis++; $display("FAIL full_mask_frames got=%0d exp=1", fd_cnt); end
        for (int i = 0; i < 4; i++) tick(0, 1);
    endtask

    task automatic test_sparse();
        mask = 8'b1010_0100; dwell = 8'd1;
        tick(1, 0);
        for (int i = 0; i < 14; i++) begin
            cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL sparse cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
            tick(0, 0);
        end
        for (int i = 0; i < 3; i++) tick(0, 1);
    endtask

    task automatic test_err();
        mask = 8'h00; dwell = 8'd3;
        tick(1, 0);
        cmp++; if (obs !== exp_vec() || err !== 1'b1) begin mis++; $display("FAIL err_pulse got=%h exp=%h", obs, exp_vec()); end
        tick(0, 0);
        cmp++; if (obs !== exp_vec() || err !== 1'b0) begin mis++; $display("FAIL err_clear got=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_stop();
        mask = 8'h08; dwell = 8'd4;
        tick(1, 0);
        cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL stop_run1 got=%h exp=%h", obs, exp_vec()); end
        tick(0, 0);
        tick(0, 1);
        for (int i = 0; i < 4; i++) begin
            cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL stop cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
            tick(0, 0);
        end
        cmp++; if ({busy, en, frame_done, sel} !== {3'b000, 3'd3}) begin
            mis++; $display("FAIL stop_exit got=%b%b%b sel=%0d exp=000 sel=3", busy, en, frame_done, sel);
        end
    endtask

    task automatic test_dwell_zero();
        mask = 8'h10; dwell = 8'd0;
        tick(1, 0);
        for (int i = 0; i < 10; i++) begin
            cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL dwell_zero cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
            tick(0, 0);
        end
        for (int i = 0; i < 3; i++) tick(0, 1);
    endtask

    task automatic test_async_reset();
        mask = 8'hFF; dwell = 8'd5;
        tick(1, 0);
        for (int i = 0; i < 10; i++) tick(0, 0);
        cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL pre_reset got=%h exp=%h", obs, exp_vec()); end
        #2 rst = 1'b1;
        #1;
        cmp++; if ({sel, en, busy} !== 5'b0) begin mis++; $display("FAIL async_reset got=%b exp=00000", {sel, en, busy}); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1, 0);
        cmp++; if (obs !== exp_vec() || sel !== 3'd0) begin mis++; $display("FAIL rescan got=%h exp=%h", obs, exp_vec()); end
        for (int i = 0; i < 7; i++) tick(0, 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            mask = 8'($urandom_range(0, 255)); dwell = 8'($urandom_range(0, 5));
            tick(1, 0);
            for (int i = 0; i < 60; i++) begin
                cmp++; if (obs !== exp_vec()) begin mis++; $display("FAIL random r=%0d cyc=%0d got=%h exp=%h", r, i, obs, exp_vec()); end
                mask = 8'($urandom_range(0, 255)); dwell = 8'($urandom_range(0, 5));
                tick(bit'($urandom % 2), ($urandom % 16) == 0);
            end
            for (int i = 0; i < 8; i++) tick(0, 1);
            cmp++; if (obs !== exp_vec() || busy !== 1'b0) begin mis++; $display("FAIL random_drain r=%0d got=%h exp=%h", r, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse();
        test_err();
        test_stop();
        test_dwell_zero();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
